// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and TX framer state type
package uart_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_parity_gen.sv
// rtl/uart_parity_gen.sv - combinational parity bit, shared by TX framer and RX checker
module uart_parity_gen
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  // Even parity makes the total count of ones even; odd makes it odd.
  assign par_bit = (par_typ == PAR_ODD) ? ~^data : ^data;

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmit framer: start, LSB-first data, optional parity, stop
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  par_bit;

  uart_parity_gen #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_bit)
  );

  // The state names the bit currently on the line; TX_OUT and busy are
  // loaded together with the state so both leave the block from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
      shift_q   <= '0;
      cnt       <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
          cnt    <= '0;
          if (DATA_VALID) begin
            shift_q   <= P_DATA;
            par_en_q  <= PAR_EN;
            par_bit_q <= par_bit;
            TX_OUT    <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          TX_OUT  <= shift_q[0];
          shift_q <= shift_q >> 1;
          cnt     <= '0;
          state   <= DATA;
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            if (par_en_q) begin
              TX_OUT <= par_bit_q;
              state  <= PARITY;
            end else begin
              TX_OUT <= 1'b1;
              state  <= STOP;
            end
          end else begin
            TX_OUT  <= shift_q[0];
            shift_q <= shift_q >> 1;
            cnt     <= cnt + 1'b1;
          end
        end
        PARITY: begin
          TX_OUT <= 1'b1;
          state  <= STOP;
        end
        STOP: begin
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] P_DATA = '0;
  logic         DATA_VALID = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic         TX_OUT;
  logic         busy;

  int compared = 0;
  int mismatched = 0;
  bit exp_bits[$];

  uart_tx_frame #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line-level reference: start 0, data LSB first, optional parity, stop 1.
  task automatic build_frame(input logic [W-1:0] d, input bit pen, input bit ptyp);
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int j = 0; j < W; j++) exp_bits.push_back(d[j]);
    if (pen) exp_bits.push_back(bit'(($countones(d) + int'(ptyp)) % 2));
    exp_bits.push_back(1'b1);
  endtask

  task automatic send(input logic [W-1:0] d, input bit pen, input bit ptyp);
    @(negedge clk);
    P_DATA = d;
    PAR_EN = pen;
    PAR_TYP = ptyp;
    DATA_VALID = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // mode 0: DATA_VALID dropped; 1: hostile inputs while busy; 2: DATA_VALID held
  task automatic expect_frame(input logic [W-1:0] d, input bit pen, input bit ptyp,
                              input int mode, input string name);
    bit got[$];
    int ones;
    build_frame(d, pen, ptyp);
    for (int i = 0; i < exp_bits.size(); i++) begin
      check($sformatf("%s tx[%0d]", name, i), 32'(TX_OUT), 32'(exp_bits[i]));
      check($sformatf("%s busy[%0d]", name, i), 32'(busy), 32'd1);
      got.push_back(TX_OUT);
      @(negedge clk);
      if (mode == 1) begin
        DATA_VALID = (i < exp_bits.size() - 1) ? 1'b1 : 1'b0;
        P_DATA = '1;
        PAR_TYP = ~PAR_TYP;
        PAR_EN = 1'($urandom_range(0, 1));
      end else if (mode == 0) begin
        DATA_VALID = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    // Receiver-side view: data plus parity must hold the promised ones parity.
    if (pen) begin
      ones = 0;
      for (int j = 1; j <= W + 1; j++) ones += int'(got[j]);
      check($sformatf("%s par_err", name), 32'(((ones % 2) != int'(ptyp))), 32'd0);
    end
  endtask

  task automatic expect_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s idle tx[%0d]", name, i), 32'(TX_OUT), 32'd1);
      check($sformatf("%s idle busy[%0d]", name, i), 32'(busy), 32'd0);
      @(negedge clk);
      DATA_VALID = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [W-1:0] d;
    bit pen, ptyp;

    #12;
    check("reset tx", 32'(TX_OUT), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    expect_idle("post_reset", 20);

    send(8'hA5, 1'b0, PAR_EVEN);
    expect_frame(8'hA5, 1'b0, PAR_EVEN, 0, "a5");
    expect_idle("a5", 2);

    send(8'h07, 1'b1, PAR_EVEN);
    expect_frame(8'h07, 1'b1, PAR_EVEN, 0, "07even");
    expect_idle("07even", 2);
    send(8'h07, 1'b1, PAR_ODD);
    expect_frame(8'h07, 1'b1, PAR_ODD, 0, "07odd");
    expect_idle("07odd", 2);

    d = W'($urandom);
    send(d, 1'b1, PAR_EVEN);
    expect_frame(d, 1'b1, PAR_EVEN, 1, "disturb");
    expect_idle("disturb", 3);

    @(negedge clk);
    P_DATA = 8'h3C;
    PAR_EN = 1'b1;
    PAR_TYP = PAR_ODD;
    DATA_VALID = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      expect_frame(8'h3C, 1'b1, PAR_ODD, 2, $sformatf("held%0d", k));
      check($sformatf("held%0d gap tx", k), 32'(TX_OUT), 32'd1);
      check($sformatf("held%0d gap busy", k), 32'(busy), 32'd0);
      if (k == 2) begin
        @(negedge clk);
        DATA_VALID = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    expect_idle("held_end", 3);

    for (int r = 0; r < 8; r++) begin
      d = W'($urandom);
      pen = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      send(d, pen, ptyp);
      expect_frame(d, pen, ptyp, 0, $sformatf("rand%0d", r));
      expect_idle($sformatf("rand%0d", r), $urandom_range(1, 3));
    end

    d = W'($urandom);
    send(d, 1'b1, PAR_EVEN);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      DATA_VALID = 1'b0;
      @(posedge clk);
      #1;
    end
    check("pre_reset bit3", 32'(TX_OUT), 32'(d[3]));
    #2;
    rst = 1'b0;
    #1;
    check("async reset tx", 32'(TX_OUT), 32'd1);
    check("async reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("held reset tx", 32'(TX_OUT), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    expect_idle("after_reset", 3);
    d = W'($urandom);
    send(d, 1'b1, PAR_ODD);
    expect_frame(d, 1'b1, PAR_ODD, 0, "recover");
    expect_idle("recover", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
